// File: rtl/mr_pkg.sv
// rtl/mr_pkg.sv - ALU op encoding, RV opcode/func3 constants and immediate helpers
package mr_pkg;

   localparam int ALU_OP_BITS = 4;

   typedef enum logic [ALU_OP_BITS-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // Immediates are returned signed so a size cast to XLEN sign-extends them.
   function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:20]};
   endfunction

   function automatic logic signed [31:0] imm_u(input logic [31:0] inst);
      return {inst[31:12], 12'h000};
   endfunction

   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      op = ALU_ADD;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         F3_AND:  op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mr_regfile.sv
// rtl/mr_regfile.sv - register file, one write port and two async read ports with WB bypass
module mr_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   input  logic [4:0]      ra1,
   output logic [XLEN-1:0] rd1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd2
);

   localparam int RW = $clog2(NREGS);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_ok;

   assign wr_ok = we && (wa != 5'd0) && (32'(wa) < NREGS);

   // Contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_ok) regs[wa[RW-1:0]] <= wd;
   end

   always_comb begin
      rd1 = '0;
      if (ra1 != 5'd0 && 32'(ra1) < NREGS) begin
         if (we && wa == ra1) rd1 = wd;
         else                 rd1 = regs[ra1[RW-1:0]];
      end
   end

   always_comb begin
      rd2 = '0;
      if (ra2 != 5'd0 && 32'(ra2) < NREGS) begin
         if (we && wa == ra2) rd2 = wd;
         else                 rd2 = regs[ra2[RW-1:0]];
      end
   end

endmodule

// File: rtl/mr_decode.sv
// rtl/mr_decode.sv - decode/operand-fetch stage with scoreboard hazard stall and flush
module mr_decode
   import mr_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NREGS      = 32,
   parameter int ALLOW_COMP = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_inst,
   input  logic [XLEN-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_arg1,
   output logic [XLEN-1:0]        out_arg2,
   output logic [4:0]             out_dst,
   output logic [ALU_OP_BITS-1:0] out_alu_op,
   output logic                   out_illegal,
   input  logic                   flush,
   input  logic                   wb_valid,
   input  logic [4:0]             wb_reg,
   input  logic [XLEN-1:0]        wb_val
);

   localparam int RW  = $clog2(NREGS);
   localparam int SHW = (XLEN == 64) ? 6 : 5;
   // imm[11:0] bits above the shift amount must be zero for shift-immediates
   localparam logic [11:0] SH_HI = 12'hFFF << SHW;

   logic [6:0] opc;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = in_inst[6:0];
   assign rd  = in_inst[11:7];
   assign f3  = in_inst[14:12];
   assign rs1 = in_inst[19:15];
   assign rs2 = in_inst[24:20];
   assign f7  = in_inst[31:25];

   logic [XLEN-1:0] rs1_val, rs2_val, imm_i_x, imm_u_x;

   assign imm_i_x = XLEN'(imm_i(in_inst));
   assign imm_u_x = XLEN'(imm_u(in_inst));

   mr_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk (clk),
      .we  (wb_valid),
      .wa  (wb_reg),
      .wd  (wb_val),
      .ra1 (rs1),
      .rd1 (rs1_val),
      .ra2 (rs2),
      .rd2 (rs2_val)
   );

   logic [XLEN-1:0] d_arg1, d_arg2;
   logic [4:0]      d_dst;
   alu_op_e         d_op;
   logic            d_ill;
   logic            use_rs1, use_rs2, use_rd;
   logic            is16;

   assign is16 = (in_inst[1:0] != 2'b11);

   always_comb begin
      d_arg1  = '0;
      d_arg2  = '0;
      d_op    = ALU_ADD;
      d_ill   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (opc)
         OPC_OP_IMM: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            d_arg1  = rs1_val;
            d_arg2  = imm_i_x;
            d_op    = alu_from_f3(f3, (f3 == F3_SR) && in_inst[30]);
            if (f3 == F3_SLL || f3 == F3_SR)
               d_ill = |(in_inst[31:20] & SH_HI & ((f3 == F3_SR) ? 12'hBFF : 12'hFFF));
         end
         OPC_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            d_arg1  = rs1_val;
            d_arg2  = rs2_val;
            d_op    = alu_from_f3(f3, f7 == F7_ALT);
            d_ill   = !((f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && (f3 == F3_ADD || f3 == F3_SR)));
         end
         OPC_LUI: begin
            use_rd = 1'b1;
            d_arg2 = imm_u_x;
         end
         OPC_AUIPC: begin
            use_rd = 1'b1;
            d_arg1 = in_pc;
            d_arg2 = imm_u_x;
         end
         default: d_ill = 1'b1;
      endcase
      // A 16-bit word is either a length error or a legal-length op we do not decode.
      if (is16 && (ALLOW_COMP == 0)) d_ill = 1'b1;
      if (is16 && (ALLOW_COMP != 0)) d_ill = 1'b1;
      if ((use_rs1 && 32'(rs1) >= NREGS) || (use_rs2 && 32'(rs2) >= NREGS) ||
          (use_rd && 32'(rd) >= NREGS))
         d_ill = 1'b1;
      if (d_ill) begin
         d_arg1  = '0;
         d_arg2  = '0;
         d_op    = ALU_ADD;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
         use_rd  = 1'b0;
      end
      d_dst = use_rd ? rd : 5'd0;
   end

   logic [NREGS-1:0] pending;
   logic             hazard, accept;

   // A writer is in flight if pending and not retiring this cycle, or sitting in the output register.
   function automatic logic reg_busy(input logic [4:0] r, input logic [NREGS-1:0] pend,
                                     input logic wbv, input logic [4:0] wbr,
                                     input logic ov, input logic [4:0] od);
      if (r == 5'd0 || 32'(r) >= NREGS) return 1'b0;
      return (pend[r[RW-1:0]] && !(wbv && wbr == r)) || (ov && od == r);
   endfunction

   assign hazard = in_valid &&
      ((use_rs1 && reg_busy(rs1, pending, wb_valid, wb_reg, out_valid, out_dst)) ||
       (use_rs2 && reg_busy(rs2, pending, wb_valid, wb_reg, out_valid, out_dst)) ||
       (use_rd  && reg_busy(rd,  pending, wb_valid, wb_reg, out_valid, out_dst)));

   assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_arg1    <= '0;
         out_arg2    <= '0;
         out_dst     <= 5'd0;
         out_alu_op  <= ALU_ADD;
         out_illegal <= 1'b0;
         pending     <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid   <= 1'b1;
            out_arg1    <= d_arg1;
            out_arg2    <= d_arg2;
            out_dst     <= d_dst;
            out_alu_op  <= d_op;
            out_illegal <= d_ill;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // Clear first so a same-cycle set of the same register wins.
         if (wb_valid && 32'(wb_reg) < NREGS)
            pending[wb_reg[RW-1:0]] <= 1'b0;
         if (out_valid && out_ready && !out_illegal && out_dst != 5'd0)
            pending[out_dst[RW-1:0]] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mr_decode.sv
// tb/tb_mr_decode.sv - scoreboard bench for mr_decode (XLEN 32 and 64 instances)
module tb_mr_decode;
   import mr_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, out_ready, flush, wb_valid;
   logic [31:0] in_inst, in_pc, wb_val;
   logic [4:0]  wb_reg;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_arg1, out_arg2;
   logic [4:0]  out_dst;
   logic [3:0]  out_alu_op;

   logic        in_valid_64, out_ready_64, flush_64, wb_valid_64;
   logic [31:0] in_inst_64;
   logic [63:0] in_pc_64, wb_val_64;
   logic [4:0]  wb_reg_64;
   logic        in_ready_64, out_valid_64, out_illegal_64;
   logic [63:0] out_arg1_64, out_arg2_64;
   logic [4:0]  out_dst_64;
   logic [3:0]  out_alu_op_64;

   mr_decode #(.XLEN(32), .NREGS(32), .ALLOW_COMP(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_arg1(out_arg1),
      .out_arg2(out_arg2), .out_dst(out_dst), .out_alu_op(out_alu_op),
      .out_illegal(out_illegal), .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_val(wb_val)
   );

   mr_decode #(.XLEN(64), .NREGS(32), .ALLOW_COMP(0)) dut_64 (
      .clk(clk), .rst(rst), .in_valid(in_valid_64), .in_ready(in_ready_64),
      .in_inst(in_inst_64), .in_pc(in_pc_64), .out_valid(out_valid_64),
      .out_ready(out_ready_64), .out_arg1(out_arg1_64), .out_arg2(out_arg2_64),
      .out_dst(out_dst_64), .out_alu_op(out_alu_op_64), .out_illegal(out_illegal_64),
      .flush(flush_64), .wb_valid(wb_valid_64), .wb_reg(wb_reg_64), .wb_val(wb_val_64)
   );

   typedef struct {
      logic [63:0] a1;
      logic [63:0] a2;
      logic [4:0]  dst;
      logic [3:0]  op;
      logic        ill;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   exp_t e32, e64;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
      end
   endtask

   task automatic exp32(input logic [63:0] a1, input logic [63:0] a2, input logic [4:0] d,
                        input logic [3:0] op, input logic ill);
      exp_t e;
      e.a1 = a1; e.a2 = a2; e.dst = d; e.op = op; e.ill = ill;
      q32.push_back(e);
   endtask

   task automatic exp64(input logic [63:0] a1, input logic [63:0] a2, input logic [4:0] d,
                        input logic [3:0] op, input logic ill);
      exp_t e;
      e.a1 = a1; e.a2 = a2; e.dst = d; e.op = op; e.ill = ill;
      q64.push_back(e);
   endtask

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (q32.size() == 0) begin
            total++; bad++;
            $display("FAIL out32_extra: got op with dst=%0d want no output", out_dst);
         end else begin
            e32 = q32.pop_front();
            chk("out32_arg1", {32'h0, out_arg1}, e32.a1);
            chk("out32_arg2", {32'h0, out_arg2}, e32.a2);
            chk("out32_dst", 64'(out_dst), 64'(e32.dst));
            chk("out32_illegal", 64'(out_illegal), 64'(e32.ill));
            if (!e32.ill) chk("out32_alu_op", 64'(out_alu_op), 64'(e32.op));
         end
      end
   end

   always @(negedge clk) begin
      if (out_valid_64 && out_ready_64) begin
         if (q64.size() == 0) begin
            total++; bad++;
            $display("FAIL out64_extra: got op with dst=%0d want no output", out_dst_64);
         end else begin
            e64 = q64.pop_front();
            chk("out64_arg1", out_arg1_64, e64.a1);
            chk("out64_arg2", out_arg2_64, e64.a2);
            chk("out64_dst", 64'(out_dst_64), 64'(e64.dst));
            chk("out64_illegal", 64'(out_illegal_64), 64'(e64.ill));
            if (!e64.ill) chk("out64_alu_op", 64'(out_alu_op_64), 64'(e64.op));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] inst);
      in_valid = 1'b1;
      in_inst  = inst;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            tick();
            in_valid = 1'b0;
            return;
         end
      end
      total++; bad++;
      $display("FAIL send32_timeout: in_ready=0 want 1 for inst 0x%08h", inst);
      in_valid = 1'b0;
   endtask

   task automatic send64(input logic [31:0] inst);
      in_valid_64 = 1'b1;
      in_inst_64  = inst;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready_64) begin
            tick();
            in_valid_64 = 1'b0;
            return;
         end
      end
      total++; bad++;
      $display("FAIL send64_timeout: in_ready=0 want 1 for inst 0x%08h", inst);
      in_valid_64 = 1'b0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] v);
      wb_valid = 1'b1;
      wb_reg   = r;
      wb_val   = v;
      tick();
      wb_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want done");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
      flush = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_val = '0;
      in_valid_64 = 1'b0; in_inst_64 = '0; in_pc_64 = '0; out_ready_64 = 1'b1;
      flush_64 = 1'b0; wb_valid_64 = 1'b0; wb_reg_64 = '0; wb_val_64 = '0;
      tick(); tick();

      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_arg1", {32'h0, out_arg1}, 64'd0);
      chk("rst_arg2", {32'h0, out_arg2}, 64'd0);
      chk("rst_dst", 64'(out_dst), 64'd0);
      chk("rst_alu_op", 64'(out_alu_op), 64'(ALU_ADD));
      chk("rst_illegal", 64'(out_illegal), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      tick();

      // addi x1,x0,5
      exp32(64'd0, 64'd5, 5'd1, ALU_ADD, 1'b0);
      send(32'h00500093);
      tick();
      wb(5'd1, 32'd5);

      // addi x1 then add x2,x1,x1: stall until WB of x1, take bypassed value
      exp32(64'd0, 64'd5, 5'd1, ALU_ADD, 1'b0);
      send(32'h00500093);
      in_valid = 1'b1;
      in_inst  = 32'h00108133;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("raw_stall_ready", 64'(in_ready), 64'd0);
         tick();
      end
      wb_valid = 1'b1; wb_reg = 5'd1; wb_val = 32'd7;
      @(negedge clk);
      chk("bypass_ready", 64'(in_ready), 64'd1);
      exp32(64'd7, 64'd7, 5'd2, ALU_ADD, 1'b0);
      tick();
      in_valid = 1'b0;
      wb_valid = 1'b0;
      tick();
      wb(5'd2, 32'h22);

      // addi x3,x1,-1 held with out_ready=0 while xori x5,x0,0xf0 waits
      out_ready = 1'b0;
      send(32'hFFF08193);
      in_valid = 1'b1;
      in_inst  = 32'h0F004293;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_arg1", {32'h0, out_arg1}, 64'd7);
         chk("hold_arg2", {32'h0, out_arg2}, 64'hFFFF_FFFF);
         chk("hold_dst", 64'(out_dst), 64'd3);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      exp32(64'd7, 64'hFFFF_FFFF, 5'd3, ALU_ADD, 1'b0);
      exp32(64'd0, 64'hF0, 5'd5, ALU_XOR, 1'b0);
      out_ready = 1'b1;
      send(32'h0F004293);
      tick();
      wb(5'd3, 32'h33);
      wb(5'd5, 32'h55);

      // illegal words, shift-amount boundary, then a legal srai
      exp32(64'd0, 64'd0, 5'd0, ALU_ADD, 1'b1);
      send(32'hFFFFFFFF);
      exp32(64'd0, 64'd0, 5'd0, ALU_ADD, 1'b1);
      send(32'h02108333);
      exp32(64'd0, 64'd0, 5'd0, ALU_ADD, 1'b1);
      send(32'h00000001);
      exp32(64'd0, 64'd0, 5'd0, ALU_ADD, 1'b1);
      send(32'h02109393);
      exp32(64'd7, 64'h403, 5'd7, ALU_SRA, 1'b0);
      send(32'h4030D393);
      tick();
      wb(5'd7, 32'h77);

      // flush kills staged addi x9 and refuses the waiting addi x5
      out_ready = 1'b0;
      send(32'h00900493);
      in_valid = 1'b1;
      in_inst  = 32'h00100293;
      flush    = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      tick();
      out_ready = 1'b1;
      exp32(64'd0, 64'd1, 5'd5, ALU_ADD, 1'b0);
      send(32'h00100293);
      tick();

      // reset during a stall with x5 pending; afterwards add x12,x5,x5 must go through
      out_ready = 1'b0;
      send(32'h00100593);
      in_valid = 1'b1;
      in_inst  = 32'h00528633;
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
      tick();
      @(negedge clk);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_dst", 64'(out_dst), 64'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      exp32(64'h55, 64'h55, 5'd12, ALU_ADD, 1'b0);
      send(32'h00528633);
      tick();
      wb(5'd12, 32'hAA);

      // auipc x3,0x1 at pc 0x100 and lui x4,0x80000
      in_pc = 32'h100;
      exp32(64'h100, 64'h1000, 5'd3, ALU_ADD, 1'b0);
      send(32'h00001197);
      exp32(64'd0, 64'h8000_0000, 5'd4, ALU_ADD, 1'b0);
      send(32'h80000237);

      // XLEN=64: sign extension and the wider shift amount
      exp64(64'd0, 64'hFFFF_FFFF_8000_0000, 5'd4, ALU_ADD, 1'b0);
      send64(32'h80000237);
      exp64(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, ALU_ADD, 1'b0);
      send64(32'hFFF00093);
      exp64(64'd0, 64'h21, 5'd7, ALU_SLL, 1'b0);
      send64(32'h02101393);

      for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) tick();
      chk("queues_drained", 64'(q32.size() + q64.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
